// File: rtl/tis_node_exec_if.sv
// Bundle of the TIS-100 node execute stage: instruction, source/destination ports,
// ALU connection and architectural state visibility.
interface tis_node_exec_if #(
  parameter int unsigned W = 11
);
  logic                instr_valid;
  logic                instr_ready;
  logic [2:0]          instr_op;
  logic [1:0]          instr_src;
  logic [1:0]          instr_dst;
  logic signed [W-1:0] instr_imm;

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data;

  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;

  logic [1:0]          alu_op;
  logic signed [W-1:0] alu_acc;
  logic signed [W-1:0] alu_src;
  logic signed [W-1:0] alu_out;

  logic signed [W-1:0] acc;
  logic signed [W-1:0] bak;
  logic                done;

  modport master (
    output instr_valid, instr_op, instr_src, instr_dst, instr_imm,
    output in_valid, in_data, out_ready, alu_out,
    input  instr_ready, in_ready, out_valid, out_data,
    input  alu_op, alu_acc, alu_src, acc, bak, done
  );

  modport slave (
    input  instr_valid, instr_op, instr_src, instr_dst, instr_imm,
    input  in_valid, in_data, out_ready, alu_out,
    output instr_ready, in_ready, out_valid, out_data,
    output alu_op, alu_acc, alu_src, acc, bak, done
  );
endinterface

// File: rtl/tis_node_exec.sv
// Execute/sequencing stage of a TIS-100 node: owns ACC/BAK, resolves the source
// operand (immediate, ACC, NIL or blocking port read) and retires via the external ALU.
module tis_node_exec #(
  parameter int unsigned W = 11
) (
  input logic             clk,
  input logic             rst,
  tis_node_exec_if.slave  bus
);
  localparam logic [2:0] OP_MOV = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_SWP = 3'b101;
  localparam logic [2:0] OP_SAV = 3'b110;

  localparam logic [1:0] SRC_IMM  = 2'b00;
  localparam logic [1:0] SRC_ACC  = 2'b01;
  localparam logic [1:0] SRC_PORT = 2'b11;

  localparam logic [1:0] DST_ACC  = 2'b00;
  localparam logic [1:0] DST_PORT = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NEG  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  state_t              r_state;
  logic [2:0]          r_op;
  logic [1:0]          r_dst;
  logic signed [W-1:0] r_operand;
  logic signed [W-1:0] r_acc;
  logic signed [W-1:0] r_bak;
  logic                r_out_valid;
  logic signed [W-1:0] r_out_data;
  logic                r_done;
  logic [1:0]          w_alu_op;
  logic                w_port_read;

  // Only MOV/ADD/SUB actually consume a PORT source; other ops ignore it.
  assign w_port_read = (bus.instr_src == SRC_PORT) &&
                       ((bus.instr_op == OP_MOV) || (bus.instr_op == OP_ADD) ||
                        (bus.instr_op == OP_SUB));

  always_comb begin
    w_alu_op = ALU_PASS;
    if (r_state == S_EXEC) begin
      case (r_op)
        OP_ADD:  w_alu_op = ALU_ADD;
        OP_SUB:  w_alu_op = ALU_SUB;
        OP_NEG:  w_alu_op = ALU_NEG;
        default: w_alu_op = ALU_PASS;
      endcase
    end
  end

  assign bus.instr_ready = (r_state == S_IDLE);
  assign bus.in_ready    = (r_state == S_READ);
  assign bus.alu_op      = w_alu_op;
  assign bus.alu_acc     = r_acc;
  assign bus.alu_src     = r_operand;
  assign bus.acc         = r_acc;
  assign bus.bak         = r_bak;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.done        = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_dst       <= '0;
      r_operand   <= '0;
      r_acc       <= '0;
      r_bak       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            r_op  <= bus.instr_op;
            r_dst <= bus.instr_dst;
            case (bus.instr_src)
              SRC_IMM: r_operand <= bus.instr_imm;
              SRC_ACC: r_operand <= r_acc;
              default: r_operand <= '0;
            endcase
            r_state <= w_port_read ? S_READ : S_EXEC;
          end
        end
        S_READ: begin
          if (bus.in_valid) begin
            r_operand <= bus.in_data;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          case (r_op)
            OP_ADD, OP_SUB, OP_NEG: r_acc <= bus.alu_out;
            OP_MOV: begin
              if (r_dst == DST_ACC) begin
                r_acc <= bus.alu_out;
              end else if (r_dst == DST_PORT) begin
                // Port write retires later, once the destination accepts.
                r_out_data  <= r_operand;
                r_out_valid <= 1'b1;
                r_done      <= 1'b0;
                r_state     <= S_WRITE;
              end
            end
            OP_SWP: begin
              r_acc <= r_bak;
              r_bak <= r_acc;
            end
            OP_SAV:  r_bak <= r_acc;
            default: ;
          endcase
        end
        S_WRITE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tis_node_exec.sv
// Scoreboard bench for tis_node_exec with a clamping ALU model attached.
module tb_tis_node_exec;
  localparam int unsigned W = 11;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MOV = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_SWP = 3'b101;
  localparam logic [2:0] OP_SAV = 3'b110;
  localparam logic [2:0] OP_NOP2 = 3'b111;

  localparam logic [1:0] S_IMM = 2'b00, S_ACC = 2'b01, S_NIL = 2'b10, S_PORT = 2'b11;
  localparam logic [1:0] D_ACC = 2'b00, D_NIL = 2'b01, D_PORT = 2'b10, D_NIL2 = 2'b11;

  typedef struct {
    int acc;
    int bak;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   out_q[$];

  tis_node_exec_if #(.W(W)) bus ();
  tis_node_exec #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Team ALU: saturates results to the legal -999..999 range.
  function automatic int alu_model(input logic [1:0] op, input int a, input int s);
    int r;
    case (op)
      2'b00:   r = a + s;
      2'b01:   r = a - s;
      2'b10:   r = -a;
      default: r = s;
    endcase
    if (r > 999) r = 999;
    if (r < -999) r = -999;
    return r;
  endfunction

  always_comb bus.alu_out = W'(alu_model(bus.alu_op, int'(bus.alu_acc), int'(bus.alu_src)));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every retire pulse and every port write handshake pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: acc %0d bak %0d with empty queue", bus.acc, bus.bak);
      end else begin
        e = exp_q.pop_front();
        chk("retire_acc", int'(bus.acc), e.acc);
        chk("retire_bak", int'(bus.bak), e.bak);
      end
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (out_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: data %0d with empty queue", bus.out_data);
      end else begin
        chk("port_write", int'(bus.out_data), out_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] src, input logic [1:0] dst,
                       input int imm, input int eacc, input int ebak, input bit push = 1'b1);
    @(posedge clk);
    #1;
    if (push) exp_q.push_back('{eacc, ebak});
    bus.instr_valid = 1'b1;
    bus.instr_op    = op;
    bus.instr_src   = src;
    bus.instr_dst   = dst;
    bus.instr_imm   = W'(imm);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.instr_ready && n < 100);
    chk("idle_reached", int'(bus.instr_ready), 1);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_op    = OP_NOP;
    bus.instr_src   = S_IMM;
    bus.instr_dst   = D_ACC;
    bus.instr_imm   = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_acc", int'(bus.acc), 0);
    chk("rst_bak", int'(bus.bak), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_instr_ready", int'(bus.instr_ready), 1);
    chk("rst_in_ready", int'(bus.in_ready), 0);

    issue(OP_ADD, S_IMM, D_ACC, 5, 5, 0);
    @(negedge clk);
    chk("alu_op_add", int'(bus.alu_op), 0);
    wait_idle();
    issue(OP_SUB, S_IMM, D_ACC, 10, -5, 0);
    wait_idle();

    issue(OP_MOV, S_IMM, D_ACC, 990, 990, 0);
    wait_idle();
    issue(OP_ADD, S_IMM, D_ACC, 50, 999, 0);
    wait_idle();
    issue(OP_NEG, S_NIL, D_ACC, 0, -999, 0);
    @(negedge clk);
    chk("alu_op_neg", int'(bus.alu_op), 2);
    wait_idle();

    // Blocking read: source stalls for three cycles.
    issue(OP_MOV, S_PORT, D_ACC, 0, 123, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("read_in_ready", int'(bus.in_ready), 1);
      chk("read_instr_ready", int'(bus.instr_ready), 0);
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = W'(123);
    @(negedge clk);
    chk("read_in_ready_last", int'(bus.in_ready), 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("read_in_ready_drop", int'(bus.in_ready), 0);
    chk("read_exec_instr_ready", int'(bus.instr_ready), 0);
    wait_idle();

    // Blocking write: destination stalls for four cycles.
    issue(OP_MOV, S_IMM, D_ACC, -7, -7, 0);
    wait_idle();
    bus.out_ready = 1'b0;
    out_q.push_back(-7);
    issue(OP_MOV, S_ACC, D_PORT, 0, -7, 0);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("write_out_valid", int'(bus.out_valid), 1);
      chk("write_out_data", int'(bus.out_data), -7);
      chk("write_no_done", int'(bus.done), 0);
      @(posedge clk);
    end
    #1 bus.out_ready = 1'b1;
    wait_idle();
    chk("write_out_valid_drop", int'(bus.out_valid), 0);

    issue(OP_MOV, S_IMM, D_ACC, 42, 42, 0);
    wait_idle();
    issue(OP_SAV, S_NIL, D_NIL, 0, 42, 42);
    wait_idle();
    issue(OP_NEG, S_NIL, D_ACC, 0, -42, 42);
    wait_idle();
    issue(OP_SWP, S_NIL, D_NIL, 0, 42, -42);
    wait_idle();
    issue(OP_NOP, S_IMM, D_ACC, 77, 42, -42);
    wait_idle();

    // PORT to PORT move passes through READ then WRITE.
    bus.in_valid = 1'b1;
    bus.in_data  = W'(77);
    out_q.push_back(77);
    issue(OP_MOV, S_PORT, D_PORT, 0, 42, -42);
    wait_idle();
    bus.in_valid = 1'b0;

    issue(OP_ADD, S_ACC, D_ACC, 0, 84, -42);
    wait_idle();
    // PORT source on NEG must not block on the (idle) input port.
    issue(OP_NEG, S_PORT, D_ACC, 0, -84, -42);
    wait_idle();
    issue(OP_NOP2, S_IMM, D_ACC, 300, -84, -42);
    wait_idle();
    issue(OP_MOV, S_IMM, D_NIL2, 500, -84, -42);
    wait_idle();

    // Asynchronous reset in the middle of a stalled write.
    bus.out_ready = 1'b0;
    issue(OP_MOV, S_ACC, D_PORT, 0, 0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_out_valid", int'(bus.out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", int'(bus.out_valid), 0);
    chk("async_rst_out_data", int'(bus.out_data), 0);
    chk("async_rst_acc", int'(bus.acc), 0);
    chk("async_rst_bak", int'(bus.bak), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_instr_ready", int'(bus.instr_ready), 1);
    chk("post_rst_in_ready", int'(bus.in_ready), 0);
    chk("post_rst_done", int'(bus.done), 0);

    issue(OP_ADD, S_IMM, D_ACC, 5, 5, 0);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("retire_queue_empty", exp_q.size(), 0);
    chk("write_queue_empty", out_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tis_node_exec.md
Name: tis_node_exec

Overview:
- Execute/sequencing stage of one TIS-100 node. It sits directly upstream of the combinational ALU: it drives ALU opcode and operands, and consumes the ALU result.
- Owns the ACC and BAK registers.
- Accepts one decoded instruction at a time.
- Resolves the source operand from an immediate, ACC, NIL or a blocking port read, then retires to ACC, BAK, NIL or a blocking port write.

Parameters:
- W, 11, datapath width (signed two's complement).
- Legal values are -999..999; saturation is done by the ALU, not here.

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  decoded instruction present
instr_ready  out  1  stage idle, can accept
instr_op  in  3  000 NOP, 001 MOV, 010 ADD, 011 SUB, 100 NEG, 101 SWP, 110 SAV, 111 = NOP
instr_src  in  2  00 IMM, 01 ACC, 10 NIL, 11 PORT
instr_dst  in  2  00 ACC, 01 NIL, 10 PORT, 11 = NIL
instr_imm  in  W  immediate operand
in_valid  in  1  source port has data
in_ready  out  1  taking source port data
in_data  in  W  source port data
out_valid  out  1  result offered to destination port
out_ready  in  1  destination port accepts
out_data  out  W  port write data
alu_op  out  2  00 ADD, 01 SUB, 10 NEG, 11 PASS (out=src)
alu_acc  out  W  ALU accumulator operand (= ACC)
alu_src  out  W  ALU source operand (= latched operand)
alu_out  in  W  ALU result (combinational)
acc  out  W  ACC register
bak  out  W  BAK register
done  out  1  one-cycle retire pulse

Behaviour:
- States: IDLE, READ, EXEC, WRITE. The state register and all outputs are registered, except alu_* and the handshake readies.
- Reset values: state IDLE; acc=0, bak=0; out_valid=0, out_data=0; done=0. Reset is asynchronous, so it takes effect mid-cycle and mid-handshake. A pending port read or write is abandoned with no partial update.
- instr_ready=1 only in IDLE.
- Accept on instr_valid && instr_ready. Latch op and dst. Latch the operand as follows:
  - IMM → imm
  - ACC → acc
  - NIL → 0
- IDLE transition on accept:
  - src=PORT and op in {MOV, ADD, SUB} → READ.
  - Otherwise → EXEC. PORT source on any other op is ignored; no read occurs.
- READ:
  - in_ready=1.
  - On in_valid, operand ← in_data and go to EXEC.
  - Waits indefinitely.
- EXEC (exactly one cycle; alu_acc=acc, alu_src=operand):
  - ADD: alu_op=00, acc ← alu_out.
  - SUB: alu_op=01, acc ← alu_out.
  - NEG: alu_op=10, acc ← alu_out.
  - MOV to ACC: alu_op=11, acc ← alu_out.
  - MOV to NIL: no state change.
  - MOV to PORT: out_data ← operand, out_valid ← 1, go to WRITE.
  - SWP: acc ← bak, bak ← acc, in the same edge.
  - SAV: bak ← acc.
  - NOP: nothing.
  - Every case except MOV to PORT: go to IDLE and set done ← 1.
  - alu_op=11 whenever the op does not use the ALU.
- WRITE:
  - out_valid=1 with out_data held stable.
  - On out_ready: out_valid ← 0, done ← 1, go to IDLE.
  - Waits indefinitely.
- done is high exactly the cycle after the retiring edge; otherwise 0.
- Latency:
  - Non-port instruction: 2 cycles accept-to-accept; ACC is updated at the second edge.
  - Each port wait adds its stall cycles.
- Source ACC uses ACC as it was at accept; ADD ACC doubles ACC, subject to ALU clamp.
- MOV PORT→PORT: operand is taken from READ, then WRITE follows; no extra state.

Test Plan:
- rst pulse, then ADD IMM 5 → acc=5 at 2nd edge after accept, done one cycle, alu_op=00; then SUB IMM 10 → acc=-5.
- acc=990, ADD IMM 50 with team ALU attached → acc=999 (clamped); NEG → acc=-999, alu_op=10.
- MOV PORT→ACC, in_valid held low 3 cycles then in_data=123 → in_ready high 3+1 cycles, instr_ready low throughout, acc=123, done one pulse.
- acc=-7, MOV ACC→PORT, out_ready low 4 cycles → out_valid=1 and out_data=-7 stable all 4 cycles, no done until out_ready; then done, out_valid=0.
- acc=42: SAV → bak=42; NEG → acc=-42; SWP → acc=42, bak=-42; NOP → registers unchanged, done pulses each time.
- Assert rst mid-WRITE (out_valid=1) → out_valid, acc, bak drop to 0 immediately before next clk edge; after release instr_ready=1, in_ready=0.
